// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Parametrised keypad matrix scanner. Drives an encoded column select, waits
// SETTLE_CYCLES for the column to settle, then samples the externally encoded
// row code. A press is accepted after DEBOUNCE_COUNT consecutive identical
// samples and a release after DEBOUNCE_COUNT consecutive non-matching samples.
// Accepted keys are offered on a valid/ready handshake. An optional
// auto-repeat re-emits the held key after REPEAT_DELAY samples, then every
// REPEAT_PERIOD samples.
//
// Ports:
//   clock         system clock
//   reset         synchronous, active-high reset
//   col_sel       encoded column currently driven
//   row_code      encoded pressed row in the selected column
//   row_valid     a key is pressed in the selected column
//   repeat_en     enables auto-repeat while a key is held
//   key_code      accepted key = col*NUM_ROWS + row
//   key_valid     key_code holds an untaken key
//   key_ready     consumer accepts key_code
//   key_held      a debounced key is currently down
//   key_released  one-cycle pulse on a debounced release
//   overrun       one-cycle pulse when an accepted key is dropped
// -----------------------------------------------------------------------------
module keypad_scanner #(
    parameter  int NUM_COLS       = 4,
    parameter  int NUM_ROWS       = 4,
    parameter  int SETTLE_CYCLES  = 16,
    parameter  int DEBOUNCE_COUNT = 4,
    parameter  int REPEAT_DELAY   = 64,
    parameter  int REPEAT_PERIOD  = 16,
    localparam int COL_W          = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1,
    localparam int ROW_W          = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
    localparam int CODE_W         = $clog2(NUM_COLS * NUM_ROWS)
) (
    input  logic              clock,
    input  logic              reset,
    output logic [COL_W-1:0]  col_sel,
    input  logic [ROW_W-1:0]  row_code,
    input  logic              row_valid,
    input  logic              repeat_en,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              key_held,
    output logic              key_released,
    output logic              overrun
);

    localparam int TMR_W   = $clog2(SETTLE_CYCLES);
    localparam int CNT_W   = $clog2(DEBOUNCE_COUNT + 1);
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HELD
    } state_t;

    state_t              state_q, state_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    cand_row_q, cand_row_d;
    logic [CNT_W-1:0]    deb_cnt_q, deb_cnt_d;
    logic [CNT_W-1:0]    rel_cnt_q, rel_cnt_d;
    logic [REP_W-1:0]    rep_cnt_q, rep_cnt_d;
    logic                rep_phase_q, rep_phase_d;   // 0: waiting for first repeat, 1: periodic
    logic [CODE_W-1:0]   key_code_q, key_code_d;
    logic                key_valid_q, key_valid_d;
    logic                key_held_q, key_held_d;
    logic                key_released_q, key_released_d;
    logic                overrun_q, overrun_d;

    logic                sample;
    logic                hit;
    logic                transfer;
    logic                accept;
    logic [COL_W-1:0]    col_next;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // through this block can leave a value unassigned and infer a latch.
        sample         = (timer_q == TMR_W'(SETTLE_CYCLES - 1));
        timer_d        = sample ? '0 : timer_q + TMR_W'(1);
        col_next       = (col_q == COL_W'(NUM_COLS - 1)) ? '0 : col_q + COL_W'(1);
        hit            = row_valid && (row_code == cand_row_q);
        transfer       = key_valid_q && key_ready;
        accept         = 1'b0;

        state_d        = state_q;
        col_d          = col_q;
        cand_row_d     = cand_row_q;
        deb_cnt_d      = deb_cnt_q;
        rel_cnt_d      = rel_cnt_q;
        rep_cnt_d      = rep_cnt_q;
        rep_phase_d    = rep_phase_q;
        key_code_d     = key_code_q;
        key_valid_d    = transfer ? 1'b0 : key_valid_q;
        key_held_d     = key_held_q;
        key_released_d = 1'b0;
        overrun_d      = 1'b0;

        case (state_q)
            ST_SCAN: begin
                if (sample) begin
                    if (row_valid) begin
                        // col_sel stays put: it is the candidate's column.
                        cand_row_d = row_code;
                        deb_cnt_d  = CNT_W'(1);
                        if (DEBOUNCE_COUNT == 1) begin
                            accept  = 1'b1;
                            state_d = ST_HELD;
                        end else begin
                            state_d = ST_DEBOUNCE;
                        end
                    end else begin
                        col_d = col_next;
                    end
                end
            end

            ST_DEBOUNCE: begin
                if (sample) begin
                    if (hit) begin
                        deb_cnt_d = deb_cnt_q + CNT_W'(1);
                        if (deb_cnt_d == CNT_W'(DEBOUNCE_COUNT)) begin
                            accept  = 1'b1;
                            state_d = ST_HELD;
                        end
                    end else begin
                        deb_cnt_d = '0;
                        state_d   = ST_SCAN;
                        col_d     = col_next;
                    end
                end
            end

            ST_HELD: begin
                if (sample) begin
                    if (hit) begin
                        rel_cnt_d = '0;
                        if (repeat_en) begin
                            rep_cnt_d = rep_cnt_q + REP_W'(1);
                            if (rep_cnt_d == (rep_phase_q ? REP_W'(REPEAT_PERIOD)
                                                          : REP_W'(REPEAT_DELAY))) begin
                                accept      = 1'b1;
                                rep_cnt_d   = '0;
                                rep_phase_d = 1'b1;
                            end
                        end else begin
                            rep_cnt_d   = '0;
                            rep_phase_d = 1'b0;
                        end
                    end else begin
                        rep_cnt_d   = '0;
                        rep_phase_d = 1'b0;
                        rel_cnt_d   = rel_cnt_q + CNT_W'(1);
                        if (rel_cnt_d == CNT_W'(DEBOUNCE_COUNT)) begin
                            rel_cnt_d      = '0;
                            deb_cnt_d      = '0;
                            key_held_d     = 1'b0;
                            key_released_d = 1'b1;
                            state_d        = ST_SCAN;
                            col_d          = col_next;
                        end
                    end
                end
            end

            default: state_d = ST_SCAN;
        endcase

        if (accept) begin
            key_held_d = 1'b1;
            // Only a free slot (or one being emptied this cycle) takes the key;
            // otherwise the untaken key is kept and the new one is dropped.
            if (!key_valid_q || transfer) begin
                key_code_d  = CODE_W'(col_q) * CODE_W'(NUM_ROWS) + CODE_W'(cand_row_d);
                key_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: state is updated with non-blocking assignments only, and the
        // synchronous reset clears every flop, discarding any pending key.
        if (reset) begin
            state_q        <= ST_SCAN;
            timer_q        <= '0;
            col_q          <= '0;
            cand_row_q     <= '0;
            deb_cnt_q      <= '0;
            rel_cnt_q      <= '0;
            rep_cnt_q      <= '0;
            rep_phase_q    <= 1'b0;
            key_code_q     <= '0;
            key_valid_q    <= 1'b0;
            key_held_q     <= 1'b0;
            key_released_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            col_q          <= col_d;
            cand_row_q     <= cand_row_d;
            deb_cnt_q      <= deb_cnt_d;
            rel_cnt_q      <= rel_cnt_d;
            rep_cnt_q      <= rep_cnt_d;
            rep_phase_q    <= rep_phase_d;
            key_code_q     <= key_code_d;
            key_valid_q    <= key_valid_d;
            key_held_q     <= key_held_d;
            key_released_q <= key_released_d;
            overrun_q      <= overrun_d;
        end
    end

    assign col_sel      = col_q;
    assign key_code     = key_code_q;
    assign key_valid    = key_valid_q;
    assign key_held     = key_held_q;
    assign key_released = key_released_q;
    assign overrun      = overrun_q;

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Parametrised keypad matrix scanner. Generalised successor of the fixed 4x4 column-scan front end used by the calculator FSM.
- Drives an encoded column select. Samples an externally encoded row code plus valid flag, and debounces per key.
- Emits one key code per press over a valid/ready handshake, with an optional auto-repeat mode.
- Sits between the keypad pins and the calculator control FSM.

Parameters:
- NUM_COLS, 4, number of keypad columns (>=2).
- NUM_ROWS, 4, number of keypad rows (>=2).
- SETTLE_CYCLES, 16, clocks each column is driven before its row inputs are sampled (>=2).
- DEBOUNCE_COUNT, 4, consecutive identical samples needed to accept a press or a release (>=1).
- REPEAT_DELAY, 64, held samples before the first auto-repeat.
- REPEAT_PERIOD, 16, held samples between later auto-repeats.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- col_sel  out  COL_W=max(1,clog2(NUM_COLS))  encoded column currently driven
- row_code  in  ROW_W=max(1,clog2(NUM_ROWS))  encoded pressed row in the selected column
- row_valid  in  1  a key is pressed in the selected column
- repeat_en  in  1  enables auto-repeat while a key is held
- key_code  out  CODE_W=clog2(NUM_COLS*NUM_ROWS)  accepted key = col*NUM_ROWS+row
- key_valid  out  1  key_code holds an untaken key
- key_ready  in  1  consumer accepts key_code
- key_held  out  1  a debounced key is currently down
- key_released  out  1  one-cycle pulse on a debounced release
- overrun  out  1  one-cycle pulse when an accepted key is dropped

Behaviour:
- Reset (sync, active-high):
  - Outputs: col_sel=0, key_code=0, key_valid=0, key_held=0, key_released=0, overrun=0.
  - Internal: state=SCAN, all counters 0.
  - Reset mid-operation discards any pending key and debounce progress. Values apply from the cycle after reset is sampled high.
- Dwell timer:
  - Counts 0..SETTLE_CYCLES-1 and restarts.
  - A "sample" is row_valid/row_code registered when the timer is at SETTLE_CYCLES-1.
  - First sample is SETTLE_CYCLES cycles after reset deasserts.
- SCAN:
  - Sample with row_valid=0: col_sel advances, wrapping NUM_COLS-1 -> 0.
  - Sample with row_valid=1: latch cand={col_sel,row_code}, set match count=1, freeze col_sel.
  - Next state is DEBOUNCE, or accept immediately if DEBOUNCE_COUNT=1.
- DEBOUNCE:
  - Sample equal to cand with row_valid=1: count++. When count reaches DEBOUNCE_COUNT, accept and go to HELD.
  - Any other sample (invalid or different row): drop cand, return to SCAN, col_sel advances.
- Accept:
  - If key_valid=0, or a transfer happens the same cycle: key_code<=cand and key_valid<=1 on the next cycle.
  - Otherwise pulse overrun; key_code is left unchanged.
  - key_held<=1.
- HELD:
  - col_sel stays frozen.
  - Each sample not matching cand increments the release count; a matching sample clears it.
  - Release count reaching DEBOUNCE_COUNT: key_held<=0, key_released pulses one cycle, state goes to SCAN, col_sel advances.
- Auto-repeat (HELD with repeat_en=1):
  - Count matching held samples from acceptance.
  - At REPEAT_DELAY, then every REPEAT_PERIOD after that, perform Accept again; the same overrun rule applies.
  - repeat_en=0, or a non-matching sample, clears the repeat count.
- Handshake:
  - Transfer occurs on a cycle with key_valid=1 and key_ready=1; key_valid drops the next cycle unless a new accept coincides.
  - key_code is stable while key_valid=1.
  - key_ready with key_valid=0 has no effect.
- Multiple simultaneous keys: only the first column found in scan order is tracked; others are ignored until release.
- All outputs are registered. No combinational path exists from inputs to outputs.

Test Plan:
Common configuration: NUM_COLS=4, NUM_ROWS=4, SETTLE_CYCLES=4, DEBOUNCE_COUNT=3, REPEAT_DELAY=8, REPEAT_PERIOD=4, key_ready=1 unless stated.
1. Reset then idle keypad (row_valid=0) -> col_sel steps 0,1,2,3,0 every 4 cycles; key_valid, key_held, overrun stay 0.
2. Press at col 2 row 1, held stable -> col_sel freezes at 2; key_valid rises 1 cycle after the 3rd matching sample with key_code=9; exactly one transfer; key_held=1.
3. Release the key from scenario 2 -> key_released pulses once after 3 non-matching samples; key_held=0; col_sel resumes at 3.
4. Bounce at col 1 row 3, samples 1,0 -> no key_valid; scan resumes at col_sel=2.
5. key_ready=0, repeat_en=1, hold key 5 -> first key_code=5 is held; overrun pulses at held samples 8 and 12; key_code stays 5; raising key_ready gives exactly one transfer.
6. repeat_en=1, key_ready=1, hold key 14 for 20 samples; separately, assert reset during DEBOUNCE -> transfers at acceptance and held samples 8, 12, 16, 20; reset returns all outputs to 0 and col_sel=0 next cycle with no key emitted.
